// File: rtl/key_schedule_ctrl.sv
// AES-256 key-schedule sequencer: drives a single-step expansion stage seven times and keeps 15 round keys.
// Define KEY_ZEROIZE_EN to add the iZeroize input that wipes the buffer and the key state.
module key_schedule_ctrl #(
    parameter int unsigned EXP_LAT = 1,
    parameter int unsigned NRK     = 15
) (
    input  logic           iClk,
    input  logic           iRst_n,
    input  logic [0:255]   iKey,
    input  logic           iKeyValid,
    output logic           oKeyReady,
    output logic           oExpEn,
    output logic [0:255]   oExpKey,
    output logic [3:0]     oCntRcon,
    input  logic [0:255]   iExpKey,
    input  logic           iRkRd,
    input  logic [3:0]     iRkIdx,
    output logic [0:127]   oRk,
    output logic           oRkValid,
`ifdef KEY_ZEROIZE_EN
    input  logic           iZeroize,
`endif
    output logic           oKeysReady
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

    localparam logic [1:0] WAIT_LAST = 2'(EXP_LAT - 1);
    localparam logic [3:0] LAST_IDX  = 4'(NRK - 1);
    localparam logic [2:0] LAST_STEP = 3'd6;

    state_e             state_q, state_d;
    logic [2:0]         step_q, step_d;
    logic [1:0]         wait_q, wait_d;
    logic [0:255]       exp_key_q, exp_key_d;
    logic [3:0]         rcon_q, rcon_d;
    logic [NRK-1:0]     valid_q, valid_d;

    logic               wr_lo_en, wr_hi_en;
    logic [3:0]         wr_lo_idx, wr_hi_idx;
    logic [0:127]       wr_lo_data, wr_hi_data;

    logic               accept;
    logic               zeroize;
    logic               rd_hit;
    logic [0:127]       rk_mem [NRK];
    logic [0:127]       rk_q;
    logic               rk_valid_q;

`ifdef KEY_ZEROIZE_EN
    assign zeroize = iZeroize;
`else
    assign zeroize = 1'b0;
`endif

    assign oKeyReady  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign oKeysReady = (state_q == S_DONE);
    assign oExpEn     = (state_q == S_ISSUE);
    assign oExpKey    = exp_key_q;
    assign oCntRcon   = rcon_q;
    assign oRk        = rk_q;
    assign oRkValid   = rk_valid_q;
    assign accept     = iKeyValid && oKeyReady;

    // NOTE: every variable gets its default before the case so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        wait_d     = wait_q;
        exp_key_d  = exp_key_q;
        rcon_d     = rcon_q;
        valid_d    = valid_q;
        wr_lo_en   = 1'b0;
        wr_hi_en   = 1'b0;
        wr_lo_idx  = {step_q, 1'b0} + 4'd2;
        wr_hi_idx  = {step_q, 1'b0} + 4'd3;
        wr_lo_data = iExpKey[0:127];
        wr_hi_data = iExpKey[128:255];

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d    = S_ISSUE;
                    step_d     = '0;
                    rcon_d     = '0;
                    exp_key_d  = iKey;
                    valid_d    = '0;
                    wr_lo_en   = 1'b1;
                    wr_hi_en   = 1'b1;
                    wr_lo_idx  = 4'd0;
                    wr_hi_idx  = 4'd1;
                    wr_lo_data = iKey[0:127];
                    wr_hi_data = iKey[128:255];
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                wait_d  = '0;
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    wr_lo_en = 1'b1;
                    if (step_q != LAST_STEP) begin
                        wr_hi_en  = 1'b1;
                        exp_key_d = iExpKey;
                        step_d    = step_q + 3'd1;
                        rcon_d    = {1'b0, step_q + 3'd1};
                        state_d   = S_ISSUE;
                    end else begin
                        // The last step yields only RK14; the upper half of the result is dropped.
                        state_d = S_DONE;
                    end
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_lo_en) valid_d[wr_lo_idx] = 1'b1;
        if (wr_hi_en) valid_d[wr_hi_idx] = 1'b1;

        if (zeroize) begin
            state_d   = S_IDLE;
            step_d    = '0;
            exp_key_d = '0;
            valid_d   = '0;
            wr_lo_en  = 1'b0;
            wr_hi_en  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            wait_q    <= '0;
            exp_key_q <= '0;
            rcon_q    <= '0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            wait_q    <= wait_d;
            exp_key_q <= exp_key_d;
            rcon_q    <= rcon_d;
            valid_q   <= valid_d;
        end
    end

    // NOTE: the round-key array is not reset; valid_q decides whether an entry may be returned.
    always_ff @(posedge iClk) begin
        if (iRst_n) begin
            if (zeroize) begin
                for (int i = 0; i < NRK; i++) rk_mem[i] <= '0;
            end else begin
                if (wr_lo_en) rk_mem[wr_lo_idx] <= wr_lo_data;
                if (wr_hi_en) rk_mem[wr_hi_idx] <= wr_hi_data;
            end
        end
    end

    assign rd_hit = (iRkIdx <= LAST_IDX) && valid_q[iRkIdx];

    // Reads see the pre-edge array, so a same-edge write returns the old contents.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            rk_q       <= '0;
            rk_valid_q <= 1'b0;
        end else begin
            rk_valid_q <= iRkRd;
            if (iRkRd) rk_q <= (rd_hit && !zeroize) ? rk_mem[iRkIdx] : '0;
        end
    end

endmodule

// File: doc/key_schedule_ctrl.md
Name: key_schedule_ctrl

Overview:
Sequencer for the AES-256 key schedule. It accepts a 256-bit cipher key over a valid/ready handshake and drives the single-step key expansion stage seven times. It stores the 15 resulting 128-bit round keys in an internal buffer. Cipher round logic downstream reads round keys from that buffer by index.

Parameters:
EXP_LAT, 1, cycles from an oExpEn pulse until iExpKey holds the expanded 256-bit result (the expansion stage's first register); legal range 1..3
NRK, 15, number of round keys stored; fixed for AES-256, not to be overridden

Ports:
iClk  in  1  clock
iRst_n  in  1  synchronous active-low reset
iKey  in  [0:255]  cipher key, bit 0 = MSB of byte 0
iKeyValid  in  1  key offer
oKeyReady  out  1  controller can accept a key
oExpEn  out  1  one-cycle step enable to the expansion stage
oExpKey  out  [0:255]  current 256-bit key state fed to the expansion stage
oCntRcon  out  [3:0]  Rcon select: 0 selects 0x01, 1 selects 0x02, up to 6 selecting 0x40
iExpKey  in  [0:255]  expanded key {xW0..xW7} returned by the expansion stage
iRkRd  in  1  round-key read request
iRkIdx  in  [3:0]  round-key index, 0..14
oRk  out  [0:127]  round key data
oRkValid  out  1  oRk valid, one-cycle pulse
oKeysReady  out  1  all 15 round keys are valid

Behaviour:
- Reset (iClk edge with iRst_n=0): state IDLE. All outputs are 0 except oKeyReady=1. Buffer contents are don't-care but are marked invalid. A reset mid-schedule aborts the schedule immediately; the stage's own reset clears it.
- Clock: all logic is on posedge iClk. Reset is synchronous, active-low, and has priority over every other event.
- Accept: iKeyValid & oKeyReady on an edge. That edge writes RK0=iKey[0:127], RK1=iKey[128:255] and oExpKey=iKey. It drops oKeyReady and oKeysReady and sets step=0.
- oKeyReady=1 only in IDLE and DONE. iKeyValid in any other state is ignored and the key is not queued.
- States IDLE -> ISSUE -> WAIT -> (ISSUE | DONE) -> IDLE-equivalent DONE.
- ISSUE: oExpEn=1 for exactly one cycle with oCntRcon=step. Next state is WAIT.
- WAIT: hold for EXP_LAT cycles with oExpEn=0. On the last WAIT edge, capture iExpKey:
  - store RK(2*step+2)=iExpKey[0:127];
  - if step<6, also store RK(2*step+3)=iExpKey[128:255], set oExpKey=iExpKey, step+1, go to ISSUE;
  - if step==6, store only RK14 (upper half is discarded) and go to DONE.
- oCntRcon holds its value outside ISSUE. oExpEn is never high for two consecutive cycles.
- DONE: oKeysReady=1 and oKeyReady=1. Accepting a new key in DONE restarts the schedule; oKeysReady falls on the acceptance edge.
- Latency: oKeysReady rises 1+7*(EXP_LAT+1) edges after the acceptance edge counted inclusively. For EXP_LAT=1 that is 15 cycles.
- Read: iRkRd on an edge gives oRk=RK[iRkIdx] and oRkValid=1 on the next cycle. With no read, oRkValid=0 and oRk holds its last value.
- Reads are honoured in any state. If the index is not yet written for the current key, or iRkIdx>14, then oRk=0 and oRkValid=1.
- A read and a buffer write to the same index on the same edge return the old contents.

Optional Feature:
KEY_ZEROIZE_EN
- Defined: adds input iZeroize (1 bit). A high sample on an edge clears all 15 buffer entries and oExpKey to 0, clears oKeysReady, and forces IDLE. Priority is below reset and above acceptance and reads; a read on that edge returns 0.
- Not defined: no port. Buffer contents persist until overwritten.

Test Plan:
- Accept key 000102..1f (FIPS-197 C.3), EXP_LAT=1 -> oExpEn pulses 7 times, oCntRcon 0..6; oKeysReady high 15 cycles after acceptance.
- After done, read idx 0,1,2,14 -> 000102030405060708090a0b0c0d0e0f, 101112131415161718191a1b1c1d1e1f, a573c29fa176c498a97fce93a572c09c, 24fc79ccbf0979e9371ac23c6d68de36, each valid one cycle after iRkRd.
- iKeyValid asserted during step 3 with key ff..ff -> ignored; oKeyReady=0; schedule finishes with the original key's RK14.
- iRst_n=0 at step 4, then new key 00..00 -> clean restart; RK2=62636363626363636263636362636363.
- Read idx 15 and idx 5 before oKeysReady -> oRk=0, oRkValid=1.
- KEY_ZEROIZE_EN: iZeroize in DONE -> oKeysReady=0; read idx 0 returns 0; state IDLE.
